// File: rtl/tt_sweep_checker.sv
// Truth-table sweeper: drives every input vector of a combinational DUT,
// holds each for HOLD cycles and scores dut_f against a latched table.
module tt_sweep_checker #(
  parameter int N_IN = 4,
  parameter int HOLD = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   exp_tt,
  input  logic                 dut_f,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt,
  output logic [N_IN-1:0]      first_err_idx,
  output logic                 first_err_vld
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [N_IN-1:0]    idx;
  logic [HW-1:0]      hold_cnt;
  logic [2**N_IN-1:0] exp_q;
  logic               accept;
  logic               sample;
  logic               last;
  logic               miss;

  assign accept = (state == S_IDLE) && start;
  assign sample = (state == S_DRIVE) && (hold_cnt == HOLD_LAST);
  assign last   = (idx == IDX_LAST);
  assign miss   = sample && (dut_f != exp_q[idx]);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_DRIVE;
      S_DRIVE: if (sample && last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decode straight from registers, so dut_in is glitch-free
  assign busy   = (state == S_DRIVE);
  assign done   = (state == S_DONE);
  assign dut_in = busy ? idx : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      hold_cnt      <= '0;
      exp_q         <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      pass          <= 1'b0;
    end else if (accept) begin
      idx           <= '0;
      hold_cnt      <= '0;
      exp_q         <= exp_tt;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      pass          <= 1'b0;
    end else if (state == S_DRIVE) begin
      hold_cnt <= sample ? '0 : hold_cnt + 1'b1;
      if (sample && !last) idx <= idx + 1'b1;
      if (miss) begin
        err_cnt <= err_cnt + 1'b1;
        if (!first_err_vld) begin
          first_err_idx <= idx;
          first_err_vld <= 1'b1;
        end
      end
      // The final compare happens on this same edge
      if (sample && last) pass <= (err_cnt == '0) && !miss;
    end
  end

endmodule
